// File: rtl/adc083000_sync_align.sv
// Sync-edge word aligner for the ADC083000 PHY: finds the sync sample phase and rotates the
// 4-sample stream so output sample 0 is sync-aligned. Optional counter: ADC083000_SYNC_ALIGN_OVR_COUNT_EN.
module adc083000_sync_align #(
    parameter int unsigned CONFIRM_COUNT = 4,
    parameter int unsigned OVR_WIDTH     = 16
) (
    input  logic                 adc_clk,
    input  logic                 ctrl_reset_n,
    input  logic [7:0]           adc_user_datai0,
    input  logic [7:0]           adc_user_datai1,
    input  logic [7:0]           adc_user_datai2,
    input  logic [7:0]           adc_user_datai3,
    input  logic [7:0]           adc_user_dataq0,
    input  logic [7:0]           adc_user_dataq1,
    input  logic [7:0]           adc_user_dataq2,
    input  logic [7:0]           adc_user_dataq3,
    input  logic                 adc_sync0,
    input  logic                 adc_sync1,
    input  logic                 adc_sync2,
    input  logic                 adc_sync3,
    input  logic                 adc_outofrange0,
    input  logic                 adc_outofrange1,
    input  logic                 adc_outofrange2,
    input  logic                 adc_outofrange3,
    input  logic                 align_en,
    input  logic                 ovr_clr,
    output logic [7:0]           aligned_datai0,
    output logic [7:0]           aligned_datai1,
    output logic [7:0]           aligned_datai2,
    output logic [7:0]           aligned_datai3,
    output logic [7:0]           aligned_dataq0,
    output logic [7:0]           aligned_dataq1,
    output logic [7:0]           aligned_dataq2,
    output logic [7:0]           aligned_dataq3,
    output logic [3:0]           aligned_sync,
    output logic [3:0]           aligned_outofrange,
    output logic                 data_valid,
    output logic [1:0]           phase,
    output logic                 phase_err,
    output logic                 ovr_flag,
    output logic [OVR_WIDTH-1:0] ovr_count
);

    localparam logic [1:0] SEARCH  = 2'd0;
    localparam logic [1:0] CHECK   = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;
    localparam logic [3:0] CONFIRM = 4'(CONFIRM_COUNT);

    // Sample n of a word lives at bits [8n +: 8] (data) or bit n (sync / out-of-range).
    logic [31:0] cur_di_q, cur_di_d, cur_dq_q, cur_dq_d;
    logic [31:0] prev_di_q, prev_di_d, prev_dq_q, prev_dq_d;
    logic [3:0]  cur_sync_q, cur_sync_d, cur_oor_q, cur_oor_d;
    logic [3:0]  prev_sync_q, prev_sync_d, prev_oor_q, prev_oor_d;
    logic [31:0] out_di_q, out_di_d, out_dq_q, out_dq_d;
    logic [3:0]  out_sync_q, out_sync_d, out_oor_q, out_oor_d;
    logic [1:0]  out_phase_q, out_phase_d;
    logic        valid_q, valid_d;
    logic [1:0]  state_q, state_d, phase_q, phase_d, cand_q, cand_d;
    logic [3:0]  cnt_q, cnt_d, cnt_inc;
    logic        err_q, err_d, ovr_flag_q, ovr_flag_d;
    logic [4:0]  sync_seq;
    logic [3:0]  edge_vec;
    logic        edge_found;
    logic [1:0]  edge_k;

    always_comb begin
        cur_di_d    = {adc_user_datai3, adc_user_datai2, adc_user_datai1, adc_user_datai0};
        cur_dq_d    = {adc_user_dataq3, adc_user_dataq2, adc_user_dataq1, adc_user_dataq0};
        cur_sync_d  = {adc_sync3, adc_sync2, adc_sync1, adc_sync0};
        cur_oor_d   = {adc_outofrange3, adc_outofrange2, adc_outofrange1, adc_outofrange0};
        prev_di_d   = cur_di_q;
        prev_dq_d   = cur_dq_q;
        prev_sync_d = cur_sync_q;
        prev_oor_d  = cur_oor_q;
        // Window is {cur, prev}; shifting by k samples takes prev[k..3] then cur[0..k-1].
        out_di_d    = 32'({cur_di_q, prev_di_q} >> {phase_q, 3'b000});
        out_dq_d    = 32'({cur_dq_q, prev_dq_q} >> {phase_q, 3'b000});
        out_sync_d  = 4'({cur_sync_q, prev_sync_q} >> phase_q);
        out_oor_d   = 4'({cur_oor_q, prev_oor_q} >> phase_q);
        out_phase_d = phase_q;
        valid_d     = (state_q == LOCKED);
    end

    always_comb begin
        sync_seq   = {cur_sync_q, prev_sync_q[3]};
        edge_vec   = sync_seq[4:1] & ~sync_seq[3:0];
        edge_found = |edge_vec;
        edge_k     = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (edge_vec[i]) edge_k = 2'(i);
        end
    end

    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (!align_en) begin
            state_d = SEARCH;
            err_d   = 1'b0;
        end else if (edge_found) begin
            case (state_q)
                SEARCH: begin
                    cand_d = edge_k;
                    cnt_d  = 4'd1;
                    if (CONFIRM <= 4'd1) begin
                        state_d = LOCKED;
                        phase_d = edge_k;
                    end else begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (edge_k == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CONFIRM) begin
                            state_d = LOCKED;
                            phase_d = cand_q;
                        end
                    end else begin
                        cand_d = edge_k;
                        cnt_d  = 4'd1;
                    end
                end
                LOCKED: begin
                    // phase_q keeps the old rotation until a new lock is confirmed.
                    if (edge_k != phase_q) begin
                        err_d   = 1'b1;
                        cand_d  = edge_k;
                        cnt_d   = 4'd1;
                        state_d = CHECK;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_comb begin
        ovr_flag_d = ovr_flag_q;
        if (ovr_clr) begin
            ovr_flag_d = 1'b0;
        end else if (|cur_oor_q) begin
            ovr_flag_d = 1'b1;
        end
    end

    always_ff @(posedge adc_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            cur_di_q    <= '0;
            cur_dq_q    <= '0;
            cur_sync_q  <= '0;
            cur_oor_q   <= '0;
            prev_di_q   <= '0;
            prev_dq_q   <= '0;
            prev_sync_q <= '0;
            prev_oor_q  <= '0;
            out_di_q    <= '0;
            out_dq_q    <= '0;
            out_sync_q  <= '0;
            out_oor_q   <= '0;
            out_phase_q <= '0;
            valid_q     <= 1'b0;
            state_q     <= SEARCH;
            phase_q     <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            ovr_flag_q  <= 1'b0;
        end else begin
            cur_di_q    <= cur_di_d;
            cur_dq_q    <= cur_dq_d;
            cur_sync_q  <= cur_sync_d;
            cur_oor_q   <= cur_oor_d;
            prev_di_q   <= prev_di_d;
            prev_dq_q   <= prev_dq_d;
            prev_sync_q <= prev_sync_d;
            prev_oor_q  <= prev_oor_d;
            out_di_q    <= out_di_d;
            out_dq_q    <= out_dq_d;
            out_sync_q  <= out_sync_d;
            out_oor_q   <= out_oor_d;
            out_phase_q <= out_phase_d;
            valid_q     <= valid_d;
            state_q     <= state_d;
            phase_q     <= phase_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            ovr_flag_q  <= ovr_flag_d;
        end
    end

`ifdef ADC083000_SYNC_ALIGN_OVR_COUNT_EN
    logic [OVR_WIDTH-1:0] ovr_count_q, ovr_count_d;

    always_comb begin
        ovr_count_d = ovr_count_q;
        if (ovr_clr) begin
            ovr_count_d = '0;
        end else if ((|cur_oor_q) && !(&ovr_count_q)) begin
            ovr_count_d = ovr_count_q + 1'b1;
        end
    end

    always_ff @(posedge adc_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            ovr_count_q <= '0;
        end else begin
            ovr_count_q <= ovr_count_d;
        end
    end

    assign ovr_count = ovr_count_q;
`else
    assign ovr_count = '0;
`endif

    assign aligned_datai0     = out_di_q[7:0];
    assign aligned_datai1     = out_di_q[15:8];
    assign aligned_datai2     = out_di_q[23:16];
    assign aligned_datai3     = out_di_q[31:24];
    assign aligned_dataq0     = out_dq_q[7:0];
    assign aligned_dataq1     = out_dq_q[15:8];
    assign aligned_dataq2     = out_dq_q[23:16];
    assign aligned_dataq3     = out_dq_q[31:24];
    assign aligned_sync       = out_sync_q;
    assign aligned_outofrange = out_oor_q;
    assign data_valid         = valid_q;
    assign phase              = out_phase_q;
    assign phase_err          = err_q;
    assign ovr_flag           = ovr_flag_q;

endmodule

// File: tb/tb_adc083000_sync_align.sv
// Self-checking bench for adc083000_sync_align: per-word expected outputs are queued as words are
// driven and compared as the aligned words emerge three edges later.
module tb_adc083000_sync_align;

`ifdef ADC083000_SYNC_ALIGN_OVR_COUNT_EN
    localparam int          SatWords    = 70000;
    localparam logic [15:0] ExpCnt100   = 16'd100;
    localparam logic [15:0] ExpSat      = 16'hFFFF;
    localparam logic [15:0] ExpAfterClr = 16'd1;
`else
    localparam int          SatWords    = 20;
    localparam logic [15:0] ExpCnt100   = 16'd0;
    localparam logic [15:0] ExpSat      = 16'd0;
    localparam logic [15:0] ExpAfterClr = 16'd0;
`endif

    logic       adc_clk;
    logic       ctrl_reset_n;
    logic [7:0] adc_user_datai0, adc_user_datai1, adc_user_datai2, adc_user_datai3;
    logic [7:0] adc_user_dataq0, adc_user_dataq1, adc_user_dataq2, adc_user_dataq3;
    logic       adc_sync0, adc_sync1, adc_sync2, adc_sync3;
    logic       adc_outofrange0, adc_outofrange1, adc_outofrange2, adc_outofrange3;
    logic       align_en, ovr_clr;
    logic [7:0] aligned_datai0, aligned_datai1, aligned_datai2, aligned_datai3;
    logic [7:0] aligned_dataq0, aligned_dataq1, aligned_dataq2, aligned_dataq3;
    logic [3:0] aligned_sync, aligned_outofrange;
    logic       data_valid;
    logic [1:0] phase;
    logic       phase_err, ovr_flag;
    logic [15:0] ovr_count;

    adc083000_sync_align dut (
        .adc_clk            (adc_clk),
        .ctrl_reset_n       (ctrl_reset_n),
        .adc_user_datai0    (adc_user_datai0),
        .adc_user_datai1    (adc_user_datai1),
        .adc_user_datai2    (adc_user_datai2),
        .adc_user_datai3    (adc_user_datai3),
        .adc_user_dataq0    (adc_user_dataq0),
        .adc_user_dataq1    (adc_user_dataq1),
        .adc_user_dataq2    (adc_user_dataq2),
        .adc_user_dataq3    (adc_user_dataq3),
        .adc_sync0          (adc_sync0),
        .adc_sync1          (adc_sync1),
        .adc_sync2          (adc_sync2),
        .adc_sync3          (adc_sync3),
        .adc_outofrange0    (adc_outofrange0),
        .adc_outofrange1    (adc_outofrange1),
        .adc_outofrange2    (adc_outofrange2),
        .adc_outofrange3    (adc_outofrange3),
        .align_en           (align_en),
        .ovr_clr            (ovr_clr),
        .aligned_datai0     (aligned_datai0),
        .aligned_datai1     (aligned_datai1),
        .aligned_datai2     (aligned_datai2),
        .aligned_datai3     (aligned_datai3),
        .aligned_dataq0     (aligned_dataq0),
        .aligned_dataq1     (aligned_dataq1),
        .aligned_dataq2     (aligned_dataq2),
        .aligned_dataq3     (aligned_dataq3),
        .aligned_sync       (aligned_sync),
        .aligned_outofrange (aligned_outofrange),
        .data_valid         (data_valid),
        .phase              (phase),
        .phase_err          (phase_err),
        .ovr_flag           (ovr_flag),
        .ovr_count          (ovr_count)
    );

    initial adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Per-word stimulus and expectations, filled by each test before streaming.
    logic [3:0]  sync_pat [0:63];
    logic [3:0]  oor_pat  [0:63];
    logic        exp_v    [0:63];
    logic [1:0]  exp_ph   [0:63];
    logic [74:0] sb [$];

    task automatic clear_patterns();
        for (int i = 0; i < 64; i++) begin
            sync_pat[i] = 4'b0;
            oor_pat[i]  = 4'b0;
            exp_v[i]    = 1'b0;
            exp_ph[i]   = 2'd0;
        end
        sb.delete();
    endtask

    // Word w carries byte count 4w+n on I and its complement on Q, so any aligned sample value
    // follows directly from its absolute sample index.
    function automatic logic [74:0] expect_word(input int w);
        logic [31:0] ei, eq;
        logic [3:0]  es, eo;
        logic [1:0]  k;
        int          idx;
        k = exp_ph[w];
        for (int j = 0; j < 4; j++) begin
            idx = j + int'(k);
            ei[8*j +: 8] = 8'(4 * w + idx);
            eq[8*j +: 8] = ~8'(4 * w + idx);
            es[j] = (idx < 4) ? sync_pat[w][idx] : sync_pat[w+1][idx-4];
            eo[j] = (idx < 4) ? oor_pat[w][idx] : oor_pat[w+1][idx-4];
        end
        return {exp_v[w], k, es, eo, ei, eq};
    endfunction

    function automatic logic [74:0] got_word();
        return {data_valid, phase, aligned_sync, aligned_outofrange,
                aligned_datai3, aligned_datai2, aligned_datai1, aligned_datai0,
                aligned_dataq3, aligned_dataq2, aligned_dataq1, aligned_dataq0};
    endfunction

    task automatic stream_word(input int w);
        logic [7:0] b;
        b = 8'(4 * w);
        adc_user_datai0 = b;          adc_user_dataq0 = ~b;
        adc_user_datai1 = b + 8'd1;   adc_user_dataq1 = ~(b + 8'd1);
        adc_user_datai2 = b + 8'd2;   adc_user_dataq2 = ~(b + 8'd2);
        adc_user_datai3 = b + 8'd3;   adc_user_dataq3 = ~(b + 8'd3);
        {adc_sync3, adc_sync2, adc_sync1, adc_sync0} = sync_pat[w];
        {adc_outofrange3, adc_outofrange2, adc_outofrange1, adc_outofrange0} = oor_pat[w];
        if (w >= 1) sb.push_back(expect_word(w - 1));
        @(posedge adc_clk);
        #1;
    endtask

    task automatic zero_inputs();
        {adc_user_datai0, adc_user_datai1, adc_user_datai2, adc_user_datai3} = '0;
        {adc_user_dataq0, adc_user_dataq1, adc_user_dataq2, adc_user_dataq3} = '0;
        {adc_sync0, adc_sync1, adc_sync2, adc_sync3} = '0;
        {adc_outofrange0, adc_outofrange1, adc_outofrange2, adc_outofrange3} = '0;
        align_en = 1'b0;
        ovr_clr  = 1'b0;
    endtask

    task automatic apply_reset();
        zero_inputs();
        ctrl_reset_n = 1'b0;
        repeat (2) @(posedge adc_clk);
        #1;
        ctrl_reset_n = 1'b1;
        clear_patterns();
    endtask

    task automatic test_reset();
        logic [74:0] got;
        zero_inputs();
        ctrl_reset_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            {adc_user_datai0, adc_user_datai1, adc_user_datai2, adc_user_datai3} = $urandom;
            {adc_user_dataq0, adc_user_dataq1, adc_user_dataq2, adc_user_dataq3} = $urandom;
            {adc_sync0, adc_sync1, adc_sync2, adc_sync3} = 4'($urandom);
            {adc_outofrange0, adc_outofrange1, adc_outofrange2, adc_outofrange3} = 4'hF;
            align_en = 1'b1;
            @(posedge adc_clk);
            #1;
            got = got_word();
            n_cmp++;
            if (got !== 75'd0) begin
                n_err++;
                $display("FAIL reset_outputs cycle %0d: got %h, expected 0", c, got);
            end
            n_cmp++;
            if ({phase_err, ovr_flag, ovr_count} !== 18'd0) begin
                n_err++;
                $display("FAIL reset_flags cycle %0d: got err=%b flag=%b cnt=%h, expected 0",
                         c, phase_err, ovr_flag, ovr_count);
            end
        end
        ctrl_reset_n = 1'b1;
    endtask

    task automatic test_lock_phase2();
        logic [74:0] got, exp;
        apply_reset();
        align_en = 1'b1;
        for (int w = 0; w < 40; w++) begin
            if (w % 8 == 1) sync_pat[w] = 4'b0100;
            if (w % 5 == 0) oor_pat[w] = 4'b0010;
            exp_v[w]  = (w >= 25);
            exp_ph[w] = (w >= 25) ? 2'd2 : 2'd0;
        end
        for (int w = 0; w < 32; w++) begin
            stream_word(w);
            if (w >= 2) begin
                exp = sb.pop_front();
                got = got_word();
                n_cmp++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL lock_phase2 word %0d: got %h, expected %h", w - 2, got, exp);
                end
            end
        end
    endtask

    task automatic test_phase0_no_edge();
        logic [74:0] got, exp;
        apply_reset();
        align_en = 1'b1;
        // Each edge at k=1 is followed by a word starting high after a high sync3: not an edge.
        for (int w = 0; w < 30; w++) begin
            if (w % 6 == 1) sync_pat[w] = 4'b1110;
            if (w % 6 == 2) sync_pat[w] = 4'b0001;
            exp_v[w]  = (w >= 19);
            exp_ph[w] = (w >= 19) ? 2'd1 : 2'd0;
        end
        for (int w = 0; w < 26; w++) begin
            stream_word(w);
            if (w >= 2) begin
                exp = sb.pop_front();
                got = got_word();
                n_cmp++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL phase0_no_edge word %0d: got %h, expected %h", w - 2, got, exp);
                end
            end
        end
    endtask

    task automatic test_phase_jump();
        logic [74:0] got, exp;
        apply_reset();
        align_en = 1'b1;
        for (int w = 0; w < 52; w++) begin
            if (w <= 25 && w % 8 == 1) sync_pat[w] = 4'b0100;
            if (w >= 29 && w % 4 == 1) sync_pat[w] = 4'b0010;
            exp_v[w]  = (w >= 25 && w < 29) || (w >= 41);
            exp_ph[w] = (w >= 41) ? 2'd1 : ((w >= 25) ? 2'd2 : 2'd0);
        end
        for (int w = 0; w < 48; w++) begin
            stream_word(w);
            if (w == 27 || w == 30) begin
                n_cmp++;
                if (phase_err !== (w == 30)) begin
                    n_err++;
                    $display("FAIL phase_err_set after word %0d: got %b, expected %b",
                             w, phase_err, (w == 30));
                end
            end
            if (w >= 2) begin
                exp = sb.pop_front();
                got = got_word();
                n_cmp++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL phase_jump word %0d: got %h, expected %h", w - 2, got, exp);
                end
            end
        end
        n_cmp++;
        if (phase_err !== 1'b1) begin
            n_err++;
            $display("FAIL phase_err_sticky: got %b, expected 1", phase_err);
        end
        align_en = 1'b0;
        @(posedge adc_clk);
        #1;
        align_en = 1'b1;
        n_cmp++;
        if (phase_err !== 1'b0) begin
            n_err++;
            $display("FAIL phase_err_clear: got %b, expected 0", phase_err);
        end
        @(posedge adc_clk);
        #1;
        n_cmp++;
        if ({data_valid, phase} !== {1'b0, 2'd1}) begin
            n_err++;
            $display("FAIL align_off_hold: got valid=%b phase=%0d, expected valid=0 phase=1",
                     data_valid, phase);
        end
    endtask

    task automatic test_ovr_counter();
        apply_reset();
        adc_outofrange2 = 1'b1;
        repeat (100) @(posedge adc_clk);
        #1;
        adc_outofrange2 = 1'b0;
        repeat (2) @(posedge adc_clk);
        #1;
        n_cmp++;
        if (ovr_count !== ExpCnt100 || ovr_flag !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_count_100: got cnt=%h flag=%b, expected cnt=%h flag=1",
                     ovr_count, ovr_flag, ExpCnt100);
        end
        adc_outofrange2 = 1'b1;
        repeat (SatWords) @(posedge adc_clk);
        #1;
        adc_outofrange2 = 1'b0;
        repeat (2) @(posedge adc_clk);
        #1;
        n_cmp++;
        if (ovr_count !== ExpSat || ovr_flag !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_saturate: got cnt=%h flag=%b, expected cnt=%h flag=1",
                     ovr_count, ovr_flag, ExpSat);
        end
        adc_outofrange2 = 1'b1;
        @(posedge adc_clk);
        #1;
        ovr_clr = 1'b1;
        @(posedge adc_clk);
        #1;
        n_cmp++;
        if (ovr_count !== 16'd0 || ovr_flag !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_clr_priority: got cnt=%h flag=%b, expected cnt=0 flag=0",
                     ovr_count, ovr_flag);
        end
        ovr_clr = 1'b0;
        adc_outofrange2 = 1'b0;
        repeat (2) @(posedge adc_clk);
        #1;
        n_cmp++;
        if (ovr_count !== ExpAfterClr || ovr_flag !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_after_clr: got cnt=%h flag=%b, expected cnt=%h flag=1",
                     ovr_count, ovr_flag, ExpAfterClr);
        end
    endtask

    task automatic test_reset_mid_check();
        logic [74:0] got, exp;
        apply_reset();
        align_en = 1'b1;
        sync_pat[1] = 4'b1000;
        sync_pat[5] = 4'b1000;
        sync_pat[9] = 4'b1000;
        for (int w = 0; w < 12; w++) begin
            stream_word(w);
            if (w >= 2) begin
                exp = sb.pop_front();
                got = got_word();
                n_cmp++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL pre_reset word %0d: got %h, expected %h", w - 2, got, exp);
                end
            end
        end
        // Asynchronous reset must clear outputs without waiting for a clock edge.
        ctrl_reset_n = 1'b0;
        #1;
        got = got_word();
        n_cmp++;
        if (got !== 75'd0 || phase_err !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got %h err=%b, expected 0", got, phase_err);
        end
        repeat (2) @(posedge adc_clk);
        #1;
        ctrl_reset_n = 1'b1;
        clear_patterns();
        for (int w = 0; w < 24; w++) begin
            if (w % 4 == 1 && w <= 13) sync_pat[w] = 4'b1000;
            exp_v[w]  = (w >= 13);
            exp_ph[w] = (w >= 13) ? 2'd3 : 2'd0;
        end
        for (int w = 0; w < 20; w++) begin
            stream_word(w);
            if (w >= 2) begin
                exp = sb.pop_front();
                got = got_word();
                n_cmp++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL relock_after_reset word %0d: got %h, expected %h",
                             w - 2, got, exp);
                end
            end
        end
    endtask

    initial begin
        zero_inputs();
        ctrl_reset_n = 1'b0;
        clear_patterns();
        test_reset();
        test_lock_phase2();
        test_phase0_no_edge();
        test_phase_jump();
        test_ovr_counter();
        test_reset_mid_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
